// File: rtl/video_pkg.sv
// Shared raster definitions: pixel source encodings, sequencer states, counter widths
// and the standard timing sets used to parametrise video_timing_ctrl.
package video_pkg;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;

  typedef enum logic [1:0] {
    SRC_TESTCARD = 2'd0,
    SRC_OSD      = 2'd1,
    SRC_PASSTHRU = 2'd2,
    SRC_BLACK    = 2'd3
  } src_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vt_state_e;

  typedef struct packed {
    int unsigned h_total;
    int unsigned h_sync;
    int unsigned h_de_start;
    int unsigned h_de_end;
    int unsigned v_total;
    int unsigned v_sync;
    int unsigned v_de_start;
    int unsigned v_de_end;
  } timing_t;

  localparam timing_t TIMING_800X600 = '{
    h_total: 1056, h_sync: 128, h_de_start: 216, h_de_end: 1016,
    v_total: 628,  v_sync: 4,   v_de_start: 27,  v_de_end: 627
  };

  localparam timing_t TIMING_640X480 = '{
    h_total: 800, h_sync: 96, h_de_start: 144, h_de_end: 784,
    v_total: 525, v_sync: 2,  v_de_start: 35,  v_de_end: 515
  };

  // Sync must finish before the active window opens, and the whole line must fit the counter.
  function automatic logic timing_ok(input int unsigned total, input int unsigned sync,
                                     input int unsigned de_start, input int unsigned de_end,
                                     input int unsigned width);
    return (sync < de_start) && (de_start < de_end) && (de_end <= total) &&
           (total <= (32'd1 << width));
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Wrap-around counter 0..TOTAL-1 with synchronous clear and a carry pulse on wrap.
// o_next exposes the value the counter will hold after the coming edge.
module raster_counter #(
  parameter int          WIDTH = 11,
  parameter int unsigned TOTAL = 1056
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] L_LAST = WIDTH'(TOTAL - 1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  logic             w_at_last;

  assign w_at_last = (r_count == L_LAST);

  // NOTE: default assignment first so every path drives w_next and no latch is inferred.
  always_comb begin
    w_next = r_count;
    if (i_clear) begin
      w_next = '0;
    end else if (i_inc) begin
      w_next = w_at_last ? '0 : r_count + WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign o_count = r_count;
  assign o_next  = w_next;
  assign o_wrap  = i_inc && !i_clear && w_at_last;

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster sequencer: H/V counters, registered syncs/data-enables aligned with the counts,
// and per-frame capture of the debug word and pixel source select.
module video_timing_ctrl
  import video_pkg::*;
#(
  parameter int unsigned H_TOTAL    = TIMING_800X600.h_total,
  parameter int unsigned H_SYNC     = TIMING_800X600.h_sync,
  parameter int unsigned H_DE_START = TIMING_800X600.h_de_start,
  parameter int unsigned H_DE_END   = TIMING_800X600.h_de_end,
  parameter int unsigned V_TOTAL    = TIMING_800X600.v_total,
  parameter int unsigned V_SYNC     = TIMING_800X600.v_sync,
  parameter int unsigned V_DE_START = TIMING_800X600.v_de_start,
  parameter int unsigned V_DE_END   = TIMING_800X600.v_de_end,
  parameter logic        HS_POL     = 1'b1,
  parameter logic        VS_POL     = 1'b1
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [63:0] dbg_in,
  input  logic [1:0]  src_sel_in,
  output logic [10:0] x_cnt,
  output logic [9:0]  y_cnt,
  output logic        hsync,
  output logic        vsync,
  output logic        hsync_de,
  output logic        vsync_de,
  output logic        de,
  output logic        frame_start,
  output logic [63:0] dbg,
  output logic [1:0]  src_sel,
  output logic        sel_ack
);

  if (!timing_ok(H_TOTAL, H_SYNC, H_DE_START, H_DE_END, H_CNT_W)) begin : g_bad_h_timing
    $error("video_timing_ctrl: inconsistent horizontal timing parameters");
  end
  if (!timing_ok(V_TOTAL, V_SYNC, V_DE_START, V_DE_END, V_CNT_W)) begin : g_bad_v_timing
    $error("video_timing_ctrl: inconsistent vertical timing parameters");
  end

  localparam logic [H_CNT_W-1:0] L_H_SYNC     = H_CNT_W'(H_SYNC);
  localparam logic [H_CNT_W-1:0] L_H_DE_START = H_CNT_W'(H_DE_START);
  localparam logic [H_CNT_W-1:0] L_H_DE_END   = H_CNT_W'(H_DE_END);
  localparam logic [V_CNT_W-1:0] L_V_SYNC     = V_CNT_W'(V_SYNC);
  localparam logic [V_CNT_W-1:0] L_V_DE_START = V_CNT_W'(V_DE_START);
  localparam logic [V_CNT_W-1:0] L_V_DE_END   = V_CNT_W'(V_DE_END);

  vt_state_e          r_state;
  vt_state_e          w_state_next;
  logic               w_cnt_inc;
  logic               w_cnt_clr;
  logic               w_run_next;
  logic               w_h_wrap;
  logic               w_v_wrap;
  logic               w_fs_next;
  logic               w_hde_next;
  logic               w_vde_next;
  logic [H_CNT_W-1:0] w_x_next;
  logic [V_CNT_W-1:0] w_y_next;

  logic               r_hsync;
  logic               r_vsync;
  logic               r_hsync_de;
  logic               r_vsync_de;
  logic               r_de;
  logic               r_frame_start;
  logic [63:0]        r_dbg;
  src_sel_e           r_src_sel;
  logic               r_sel_ack;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Dropping enable clears the counters on the very next edge, even mid-line.
  always_comb begin
    w_state_next = r_state;
    w_cnt_inc    = 1'b0;
    w_cnt_clr    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (enable) w_state_next = ST_RUN;
        else        w_cnt_clr    = 1'b1;
      end
      ST_RUN: begin
        if (enable) begin
          w_cnt_inc = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
          w_cnt_clr    = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_clr    = 1'b1;
      end
    endcase
  end

  raster_counter #(.WIDTH(H_CNT_W), .TOTAL(H_TOTAL)) u_h_cnt (
    .vga_clk (vga_clk),
    .reset   (reset),
    .i_clear (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .o_count (x_cnt),
    .o_next  (w_x_next),
    .o_wrap  (w_h_wrap)
  );

  raster_counter #(.WIDTH(V_CNT_W), .TOTAL(V_TOTAL)) u_v_cnt (
    .vga_clk (vga_clk),
    .reset   (reset),
    .i_clear (w_cnt_clr),
    .i_inc   (w_h_wrap),
    .o_count (y_cnt),
    .o_next  (w_y_next),
    .o_wrap  (w_v_wrap)
  );

  // Next position is (0,0) while running either on a frame wrap or on the IDLE->RUN step.
  assign w_run_next = (w_state_next == ST_RUN);
  assign w_fs_next  = ((r_state == ST_IDLE) && enable) || w_v_wrap;
  assign w_hde_next = w_run_next && (w_x_next >= L_H_DE_START) && (w_x_next < L_H_DE_END);
  assign w_vde_next = w_run_next && (w_y_next >= L_V_DE_START) && (w_y_next < L_V_DE_END);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_hsync_de    <= 1'b0;
      r_vsync_de    <= 1'b0;
      r_de          <= 1'b0;
      r_frame_start <= 1'b0;
      r_dbg         <= '0;
      r_src_sel     <= SRC_TESTCARD;
      r_sel_ack     <= 1'b0;
    end else begin
      r_hsync       <= (w_run_next && (w_x_next < L_H_SYNC)) ? HS_POL : ~HS_POL;
      r_vsync       <= (w_run_next && (w_y_next < L_V_SYNC)) ? VS_POL : ~VS_POL;
      r_hsync_de    <= w_hde_next;
      r_vsync_de    <= w_vde_next;
      r_de          <= w_hde_next && w_vde_next;
      r_frame_start <= w_fs_next;
      r_sel_ack     <= 1'b0;
      if (w_fs_next) begin
        r_dbg     <= dbg_in;
        r_src_sel <= src_sel_e'(src_sel_in);
        r_sel_ack <= (src_sel_e'(src_sel_in) != r_src_sel);
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign hsync_de    = r_hsync_de;
  assign vsync_de    = r_vsync_de;
  assign de          = r_de;
  assign frame_start = r_frame_start;
  assign dbg         = r_dbg;
  assign src_sel     = r_src_sel;
  assign sel_ack     = r_sel_ack;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench: one instance with the 800x600 defaults for line-level and reset checks,
// one with a tiny 20x12 raster (negative hsync) so whole frames stay short.
module tb_video_timing_ctrl;

  localparam logic [63:0] DBG_A = 64'hA5A5_0000_1234_5678;
  localparam logic [63:0] DBG_B = 64'h0F0F_FFFF_8765_4321;
  localparam logic [63:0] DBG_D = 64'hDEAD_BEEF_0123_4567;

  logic clk;

  logic        f_reset, f_enable;
  logic [63:0] f_dbg_in;
  logic [1:0]  f_src_in;
  logic [10:0] f_x;
  logic [9:0]  f_y;
  logic        f_hs, f_vs, f_hde, f_vde, f_de, f_fs, f_ack;
  logic [63:0] f_dbg;
  logic [1:0]  f_src;

  logic        s_reset, s_enable;
  logic [63:0] s_dbg_in;
  logic [1:0]  s_src_in;
  logic [10:0] s_x;
  logic [9:0]  s_y;
  logic        s_hs, s_vs, s_hde, s_vde, s_de, s_fs, s_ack;
  logic [63:0] s_dbg;
  logic [1:0]  s_src;

  int n_checks = 0;
  int n_errors = 0;

  video_timing_ctrl u_dut_full (
    .vga_clk(clk), .reset(f_reset), .enable(f_enable), .dbg_in(f_dbg_in),
    .src_sel_in(f_src_in), .x_cnt(f_x), .y_cnt(f_y), .hsync(f_hs), .vsync(f_vs),
    .hsync_de(f_hde), .vsync_de(f_vde), .de(f_de), .frame_start(f_fs),
    .dbg(f_dbg), .src_sel(f_src), .sel_ack(f_ack)
  );

  video_timing_ctrl #(
    .H_TOTAL(20), .H_SYNC(3), .H_DE_START(5), .H_DE_END(17),
    .V_TOTAL(12), .V_SYNC(2), .V_DE_START(3), .V_DE_END(10),
    .HS_POL(1'b0), .VS_POL(1'b1)
  ) u_dut_small (
    .vga_clk(clk), .reset(s_reset), .enable(s_enable), .dbg_in(s_dbg_in),
    .src_sel_in(s_src_in), .x_cnt(s_x), .y_cnt(s_y), .hsync(s_hs), .vsync(s_vs),
    .hsync_de(s_hde), .vsync_de(s_vde), .de(s_de), .frame_start(s_fs),
    .dbg(s_dbg), .src_sel(s_src), .sel_ack(s_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int de_cnt, vs_cnt, hs_cnt, fs_cnt;
    logic [5:0] exp_flags;

    f_reset = 1'b1; f_enable = 1'b1; f_dbg_in = DBG_D; f_src_in = 2'd1;
    s_reset = 1'b1; s_enable = 1'b1; s_dbg_in = DBG_A; s_src_in = 2'd0;
    tick_n(2);

    // Small raster: reset values (hsync idles high because HS_POL=0)
    check("s_rst_x", 64'(s_x), 64'd0);
    check("s_rst_y", 64'(s_y), 64'd0);
    check("s_rst_flags", 64'({s_hs, s_vs, s_hde, s_vde, s_de, s_fs, s_ack}), 64'b1000000);
    check("s_rst_dbg", s_dbg, 64'd0);

    s_reset = 1'b0;
    tick();
    check("s_f1_dbg", s_dbg, DBG_A);
    check("s_f1_src", 64'(s_src), 64'd0);
    check("s_f1_ack", 64'(s_ack), 64'd0);

    // One full frame against a position/flag model
    de_cnt = 0; vs_cnt = 0; hs_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 240; i++) begin
      int x, y;
      x = i % 20;
      y = i / 20;
      exp_flags[5] = (x < 3) ? 1'b0 : 1'b1;
      exp_flags[4] = (y < 2);
      exp_flags[3] = (x >= 5) && (x < 17);
      exp_flags[2] = (y >= 3) && (y < 10);
      exp_flags[1] = exp_flags[3] && exp_flags[2];
      exp_flags[0] = (i == 0);
      check($sformatf("s_pos_%0d", i), 64'({s_y, s_x}), 64'({y[9:0], x[10:0]}));
      check($sformatf("s_flags_%0d", i), 64'({s_hs, s_vs, s_hde, s_vde, s_de, s_fs}),
            64'(exp_flags));
      de_cnt += int'(s_de);
      vs_cnt += int'(s_vs);
      hs_cnt += int'(!s_hs);
      fs_cnt += int'(s_fs);
      tick();
    end
    check("s_de_count", 64'(de_cnt), 64'd84);
    check("s_vs_count", 64'(vs_cnt), 64'd40);
    check("s_hs_count", 64'(hs_cnt), 64'd36);
    check("s_fs_count", 64'(fs_cnt), 64'd1);
    check("s_f2_fs", 64'(s_fs), 64'd1);
    check("s_f2_pos", 64'({s_y, s_x}), 64'd0);

    // Debug word changed mid-frame is held off until the next frame start
    tick_n(120);
    check("s_y300eq", 64'(s_y), 64'd6);
    s_dbg_in = DBG_B;
    tick();
    check("s_dbg_hold0", s_dbg, DBG_A);
    tick_n(118);
    check("s_dbg_hold1", s_dbg, DBG_A);
    check("s_last_pos", 64'({s_y, s_x}), 64'({10'd11, 11'd19}));
    check("s_last_fs", 64'(s_fs), 64'd0);
    tick();
    check("s_f3_fs", 64'(s_fs), 64'd1);
    check("s_f3_dbg", s_dbg, DBG_B);
    check("s_f3_ack", 64'(s_ack), 64'd0);

    // Source select: two mid-frame changes, last one wins at frame start
    tick_n(100);
    s_src_in = 2'd1;
    tick_n(50);
    check("s_src_hold0", 64'(s_src), 64'd0);
    s_src_in = 2'd2;
    tick_n(89);
    check("s_src_hold1", 64'(s_src), 64'd0);
    check("s_ack_hold", 64'(s_ack), 64'd0);
    tick();
    check("s_f4_fs", 64'(s_fs), 64'd1);
    check("s_f4_src", 64'(s_src), 64'd2);
    check("s_f4_ack", 64'(s_ack), 64'd1);
    tick();
    check("s_ack_pulse", 64'(s_ack), 64'd0);
    tick_n(239);
    check("s_f5_fs", 64'(s_fs), 64'd1);
    check("s_f5_src", 64'(s_src), 64'd2);
    check("s_f5_ack", 64'(s_ack), 64'd0);

    // Disable mid-line inside the active window, then restart
    tick_n(130);
    check("s_pre_dis_pos", 64'({s_y, s_x}), 64'({10'd6, 11'd10}));
    check("s_pre_dis_de", 64'(s_de), 64'd1);
    s_enable = 1'b0;
    tick();
    check("s_dis_pos", 64'({s_y, s_x}), 64'd0);
    check("s_dis_flags", 64'({s_hs, s_vs, s_hde, s_vde, s_de, s_fs, s_ack}), 64'b1000000);
    check("s_dis_dbg", s_dbg, DBG_B);
    check("s_dis_src", 64'(s_src), 64'd2);
    tick_n(3);
    check("s_idle_pos", 64'({s_y, s_x}), 64'd0);
    check("s_idle_fs", 64'(s_fs), 64'd0);
    s_enable = 1'b1;
    tick();
    check("s_run_pos", 64'({s_y, s_x}), 64'd0);
    check("s_run_flags", 64'({s_hs, s_vs, s_fs, s_ack}), 64'b0110);
    tick();
    check("s_run_x1", 64'(s_x), 64'd1);
    check("s_run_fs1", 64'(s_fs), 64'd0);

    // 800x600 instance: reset state with enable already high
    check("f_rst_pos", 64'({f_y, f_x}), 64'd0);
    check("f_rst_flags", 64'({f_hs, f_vs, f_hde, f_vde, f_de, f_fs, f_ack}), 64'd0);
    check("f_rst_dbg", f_dbg, 64'd0);
    check("f_rst_src", 64'(f_src), 64'd0);

    f_reset = 1'b0;
    tick();
    check("f_fs_dbg", f_dbg, DBG_D);
    check("f_fs_src", 64'(f_src), 64'd1);
    for (int i = 0; i < 1056; i++) begin
      exp_flags[5] = (i < 128);
      exp_flags[4] = 1'b1;
      exp_flags[3] = (i >= 216) && (i < 1016);
      exp_flags[2] = 1'b0;
      exp_flags[1] = 1'b0;
      exp_flags[0] = (i == 0);
      check($sformatf("f_pos_%0d", i), 64'({f_y, f_x}), 64'(i));
      check($sformatf("f_flags_%0d", i), 64'({f_hs, f_vs, f_hde, f_vde, f_de, f_fs}),
            64'(exp_flags));
      check($sformatf("f_ack_%0d", i), 64'(f_ack), 64'(i == 0));
      tick();
    end
    check("f_wrap_pos", 64'({f_y, f_x}), 64'({10'd1, 11'd0}));
    check("f_wrap_fs", 64'(f_fs), 64'd0);
    check("f_wrap_vs", 64'(f_vs), 64'd1);

    // Reset mid-line while enabled
    tick_n(300);
    check("f_mid_pos", 64'({f_y, f_x}), 64'({10'd1, 11'd300}));
    check("f_mid_hde", 64'(f_hde), 64'd1);
    f_reset = 1'b1;
    tick();
    check("f_rst2_pos", 64'({f_y, f_x}), 64'd0);
    check("f_rst2_flags", 64'({f_hs, f_vs, f_hde, f_vde, f_de, f_fs, f_ack}), 64'd0);
    check("f_rst2_dbg", f_dbg, 64'd0);
    check("f_rst2_src", 64'(f_src), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
